// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_pipe block.
package mux_pkg;

  localparam int unsigned NUM_MIN = 2;
  localparam int unsigned NUM_MAX = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 selector; an out-of-range select yields zero data and flags oob_o.
module mux_n import mux_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NUM   = 3,
  localparam int unsigned SEL_W = clog2(NUM)
) (
  input  logic [SEL_W-1:0]     sel_i,
  input  logic [NUM*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 oob_o
);

  always_comb begin
    data_o = '0;
    oob_o  = 1'b1;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = data_i[k*WIDTH +: WIDTH];
        oob_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Registered channel selector with valid/ready handshakes, flush and sticky out-of-range flag.
// Define MUX_PIPE_SKID_EN to add a skid entry behind the output register (registered in_ready).
module mux_pipe import mux_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NUM   = 3,
  localparam int unsigned SEL_W = clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     ctrl,
  input  logic [NUM*WIDTH-1:0] din,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_oob,
  input  logic                 err_clr
);

  if (NUM < NUM_MIN || NUM > NUM_MAX) begin : g_num_range
    $error("mux_pipe: NUM out of range");
  end

  logic [WIDTH-1:0] sel_data;
  logic             sel_oob;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             accept;

  mux_n #(
    .WIDTH(WIDTH),
    .NUM  (NUM)
  ) u_mux_n (
    .sel_i (ctrl),
    .data_i(din),
    .data_o(sel_data),
    .oob_o (sel_oob)
  );

  assign accept = in_valid && in_ready;

`ifdef MUX_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             skid_valid_q, skid_valid_d;

  // Ready depends only on flop state (plus flush, which blocks acceptance outright).
  assign in_ready = !flush && !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_d        = '0;
      out_valid_d  = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = sel_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = sel_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign in_ready = !flush && (!out_valid_q || out_ready);

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = sel_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      // Data is kept on drain; only the valid bit drops.
      out_valid_d = 1'b0;
    end
  end
`endif

  // Set takes priority over clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (accept && sel_oob) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err_oob   = err_q;

endmodule

// File: tb/tb_mux_pipe.sv
// Scoreboard bench for mux_pipe (NUM=3, WIDTH=32); builds with or without MUX_PIPE_SKID_EN.
module tb_mux_pipe;

`ifdef MUX_PIPE_SKID_EN
  localparam int STALL_ACCEPTS = 2;
`else
  localparam int STALL_ACCEPTS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ctrl = '0;
  logic [95:0] din = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] out_w;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        err_oob;
  logic        err_clr = 1'b0;

  int total = 0;
  int bad = 0;
  int npop = 0;
  logic [31:0] exp_q[$];
  logic        rdy_toggle = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = '0;

  mux_pipe u_dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl     (ctrl),
    .din      (din),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out      (out_w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_oob  (err_oob),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: pops on every downstream transfer and checks hold-while-stalled.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", out_w, prev_out);
    end
    if (out_valid && out_ready && !flush && !reset) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", out_w);
      end else begin
        check("scoreboard", out_w, exp_q.pop_front());
        npop++;
      end
    end
    prev_stall = out_valid && !out_ready && !flush && !reset;
    prev_out   = out_w;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_toggle) out_ready = !out_ready;
  end

  function automatic logic [95:0] pack(input logic [31:0] c0, input logic [31:0] c1,
                                       input logic [31:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic send(input logic [1:0] c, input logic [95:0] d, input logic [31:0] e);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    ctrl = c;
    din = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while ((out_valid || exp_q.size() != 0) && n < 100) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (out_valid || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", exp_q.size());
    end
  endtask

  initial begin
    int acc;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out", out_w, 32'h0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err", {31'd0, err_oob}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // Basic selection and latency
    send(2'd2, pack(32'h11111111, 32'h22222222, 32'hDEADBEEF), 32'hDEADBEEF);
    @(negedge clk);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data", out_w, 32'hDEADBEEF);
    send(2'd0, pack(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2), 32'hA0A0A0A0);
    send(2'd1, pack(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2), 32'hB1B1B1B1);
    wait_empty();
    check("no_err", {31'd0, err_oob}, 32'd0);

    // Out-of-range select, sticky flag, clear, set-wins
    send(2'd3, pack(32'h1, 32'h2, 32'h3), 32'h0);
    wait_empty();
    check("oob_set", {31'd0, err_oob}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("oob_sticky", {31'd0, err_oob}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("oob_clr", {31'd0, err_oob}, 32'd0);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    send(2'd3, pack(32'h4, 32'h5, 32'h6), 32'h0);
    err_clr = 1'b0;
    @(negedge clk);
    check("oob_set_wins", {31'd0, err_oob}, 32'd1);
    wait_empty();

    // Stream 1..8 with toggling out_ready
    npop = 0;
    rdy_toggle = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(2'd0, pack(32'(i), 32'hFFFF0000, 32'h0000FFFF), 32'(i));
    end
    wait_empty();
    rdy_toggle = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    check("stream_count", 32'(npop), 32'd8);

    // Stalled sink: count acceptances
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc = 0;
    ctrl = 2'd1;
    din = pack(32'h0, 32'h00000055, 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(32'h00000055);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stall_accepts", 32'(acc), 32'(STALL_ACCEPTS));
    @(negedge clk);
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty();

    // Flush discards buffered and same-cycle data
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'd1, pack(32'h0, 32'h0BADF00D, 32'h0), 32'h0BADF00D);
    flush = 1'b1;
    in_valid = 1'b1;
    ctrl = 2'd2;
    din = pack(32'h0, 32'h0, 32'hFEEDFACE);
    @(negedge clk);
    check("flush_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out", out_w, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_quiet", {31'd0, out_valid}, 32'd0);
    end

    // Reset while stalled
    send(2'd3, pack(32'h7, 32'h8, 32'h9), 32'h0);
    wait_empty();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'd2, pack(32'h0, 32'h0, 32'hCAFEF00D), 32'hCAFEF00D);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst2_out", out_w, 32'h0);
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_err", {31'd0, err_oob}, 32'd0);
    check("rst2_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_quiet", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
